// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer state encoding and limb-count derivation.
// Pure constants and constant functions; no latency or flow-control behaviour of its own.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int n_limbs(input int operand_width, input int adder_width);
    return operand_width / adder_width;
  endfunction

  // A single-limb configuration still needs a 1-bit counter to stay a legal vector.
  function automatic int cnt_width(input int limbs);
    return (limbs > 1) ? $clog2(limbs) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_Nb.sv
// Combinational N-bit ripple-carry adder used as the per-limb datapath.
// Zero latency, no flow control; the carry chain is confined to one limb.
module ripple_carry_adder_Nb #(
  parameter int ADDER_WIDTH = 8
) (
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  input  logic                   carry_in,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic                   carry_out
);

  logic [ADDER_WIDTH:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry[ADDER_WIDTH];

endmodule

// File: rtl/mp_adder_sequencer.sv
// Multi-precision add/subtract, one ADDER_WIDTH limb per cycle; oDone N_LIMBS+1 cycles after accept.
// Accepts iStart only in IDLE (oReady); requests while busy are dropped, never queued.
module mp_adder_sequencer
  import arith_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int ADDER_WIDTH   = 8
) (
  input  logic                     iClk,
  input  logic                     iRstn,
  input  logic                     iStart,
  input  logic                     iSub,
  input  logic [OPERAND_WIDTH-1:0] iA,
  input  logic [OPERAND_WIDTH-1:0] iB,
  input  logic                     iCarry,
  output logic                     oReady,
  output logic                     oDone,
  output logic [OPERAND_WIDTH-1:0] oSum,
  output logic                     oCarry
);

  localparam int N_LIMBS = n_limbs(OPERAND_WIDTH, ADDER_WIDTH);
  localparam int CNT_W   = cnt_width(N_LIMBS);
  localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(N_LIMBS - 1);

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     carry_q, carry_d;
  logic [OPERAND_WIDTH-1:0] a_q, a_d;
  logic [OPERAND_WIDTH-1:0] b_q, b_d;
  logic [OPERAND_WIDTH-1:0] res_q, res_d;
  logic [OPERAND_WIDTH-1:0] sum_q, sum_d;
  logic                     cout_q, cout_d;

  logic [ADDER_WIDTH-1:0]   limb_a, limb_b, limb_sum;
  logic                     limb_cout;
  int                       limb_base;

  assign limb_base = int'(cnt_q) * ADDER_WIDTH;
  assign limb_a    = a_q[limb_base +: ADDER_WIDTH];
  assign limb_b    = b_q[limb_base +: ADDER_WIDTH];

  ripple_carry_adder_Nb #(
    .ADDER_WIDTH (ADDER_WIDTH)
  ) u_limb_adder (
    .a         (limb_a),
    .b         (limb_b),
    .carry_in  (carry_q),
    .sum       (limb_sum),
    .carry_out (limb_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d = ST_ADD;
          cnt_d   = '0;
          a_d     = iA;
          // Subtraction is A + ~B + 1; the +1 rides in as the initial carry.
          b_d     = iSub ? ~iB : iB;
          carry_d = iSub ? 1'b1 : iCarry;
        end
      end
      ST_ADD: begin
        res_d[limb_base +: ADDER_WIDTH] = limb_sum;
        carry_d = limb_cout;
        if (cnt_q == LAST_LIMB) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          sum_d   = res_d;
          cout_d  = limb_cout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign oReady = (state_q == ST_IDLE);
  assign oDone  = (state_q == ST_DONE);
  assign oSum   = sum_q;
  assign oCarry = cout_q;

endmodule

// File: tb/tb_mp_adder_sequencer.sv
// Bench for mp_adder_sequencer at 16-bit operands with 4-bit limbs.
module tb_mp_adder_sequencer;

  localparam int OW = 16;
  localparam int AW = 4;
  localparam int NL = OW / AW;

  logic          iClk = 1'b0;
  logic          iRstn, iStart, iSub, iCarry;
  logic [OW-1:0] iA, iB;
  logic          oReady, oDone, oCarry;
  logic [OW-1:0] oSum;

  int checks   = 0;
  int failures = 0;

  logic [OW-1:0] last_sum;
  logic          last_carry;

  mp_adder_sequencer #(
    .OPERAND_WIDTH (OW),
    .ADDER_WIDTH   (AW)
  ) dut (
    .iClk   (iClk),
    .iRstn  (iRstn),
    .iStart (iStart),
    .iSub   (iSub),
    .iA     (iA),
    .iB     (iB),
    .iCarry (iCarry),
    .oReady (oReady),
    .oDone  (oDone),
    .oSum   (oSum),
    .oCarry (oCarry)
  );

  always #5 iClk = ~iClk;

  // Reference: plain integer arithmetic; carry in subtract mode means "no borrow".
  function automatic logic [OW:0] model(input bit sub, input logic [OW-1:0] a,
                                        input logic [OW-1:0] b, input bit cin);
    logic [OW:0] r;
    if (sub) begin
      r[OW-1:0] = a - b;
      r[OW]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{OW{1'b0}}, cin};
    end
    return r;
  endfunction

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic start_op(input bit sub, input logic [OW-1:0] a, input logic [OW-1:0] b,
                          input bit cin);
    int n = 0;
    while (!oReady && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!oReady) begin
      failures++;
      $display("FAIL ready_timeout: oReady=%0b after %0d cycles, required 1", oReady, n);
    end
    iStart = 1'b1;
    iSub   = sub;
    iA     = a;
    iB     = b;
    iCarry = cin;
  endtask

  // First edge is the accepting edge; operands are scrambled right after it.
  task automatic wait_done(output int cyc, output bit timed_out, output bit held_ok);
    cyc       = 0;
    timed_out = 1'b1;
    held_ok   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      cyc++;
      if (i == 0) begin
        iStart = 1'b0;
        iA     = OW'($urandom);
        iB     = OW'($urandom);
        iSub   = 1'($urandom);
        iCarry = 1'($urandom);
      end
      if (oDone) begin
        timed_out = 1'b0;
        break;
      end
      if (oSum !== last_sum || oCarry !== last_carry) held_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    iRstn = 1'b0; iStart = 1'b0; iSub = 1'b0; iCarry = 1'b0; iA = '0; iB = '0;
    step();
    step();
    checks++;
    if (oReady !== 1'b1 || oDone !== 1'b0 || oSum !== '0 || oCarry !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: ready=%0b done=%0b sum=%h carry=%0b, required 1 0 0000 0",
               oReady, oDone, oSum, oCarry);
    end
    iRstn      = 1'b1;
    last_sum   = '0;
    last_carry = 1'b0;
    step();
    checks++;
    if (oReady !== 1'b1 || oDone !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: ready=%0b done=%0b, required 1 0", oReady, oDone);
    end
  endtask

  task automatic test_fixed_vectors();
    bit            v_sub   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [OW-1:0] v_a     [4] = '{16'hFFFF, 16'h1234, 16'h0001, 16'h1234};
    logic [OW-1:0] v_b     [4] = '{16'h0001, 16'h4321, 16'h0002, 16'h1234};
    bit            v_cin   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [OW-1:0] v_sum   [4] = '{16'h0000, 16'h5556, 16'hFFFF, 16'h0000};
    bit            v_carry [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int cyc;
    bit to, held;
    for (int k = 0; k < 4; k++) begin
      start_op(v_sub[k], v_a[k], v_b[k], v_cin[k]);
      wait_done(cyc, to, held);
      checks++;
      if (to || cyc != NL + 1) begin
        failures++;
        $display("FAIL fixed_latency[%0d]: cycles=%0d timeout=%0b, required %0d", k, cyc, to, NL + 1);
      end
      checks++;
      if (oSum !== v_sum[k] || oCarry !== v_carry[k]) begin
        failures++;
        $display("FAIL fixed_result[%0d]: sum=%h carry=%0b, required %h %0b",
                 k, oSum, oCarry, v_sum[k], v_carry[k]);
      end
      checks++;
      if (!held) begin
        failures++;
        $display("FAIL fixed_hold[%0d]: output changed before done, required %h %0b",
                 k, last_sum, last_carry);
      end
      last_sum   = v_sum[k];
      last_carry = v_carry[k];
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    logic [OW:0] exp = model(1'b0, 16'h1111, 16'h2222, 1'b0);
    start_op(1'b0, 16'h1111, 16'h2222, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      step();
      iStart = (i == 2 || i == 3);
      iA     = OW'($urandom);
      iB     = OW'($urandom);
      iSub   = 1'($urandom);
      if (i <= NL + 1) begin
        checks++;
        if (oReady !== 1'b0) begin
          failures++;
          $display("FAIL busy_ready[%0d]: oReady=%0b, required 0", i, oReady);
        end
      end
      if (oDone) begin
        dones++;
        checks++;
        if (i != NL + 1 || oSum !== exp[OW-1:0] || oCarry !== exp[OW]) begin
          failures++;
          $display("FAIL busy_result: cycle=%0d sum=%h carry=%0b, required %0d %h %0b",
                   i, oSum, oCarry, NL + 1, exp[OW-1:0], exp[OW]);
        end
      end
    end
    iStart = 1'b0;
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL busy_done_count: dones=%0d, required 1", dones);
    end
    last_sum   = exp[OW-1:0];
    last_carry = exp[OW];
  endtask

  task automatic test_reset_abort();
    int cyc, dones = 0;
    bit to, held;
    start_op(1'b0, 16'h00F0, 16'h0F0F, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) iStart = 1'b0;
      if (i == 3) iRstn = 1'b0;
      if (oDone) dones++;
    end
    checks++;
    if (dones != 0 || oSum !== '0 || oCarry !== 1'b0 || oReady !== 1'b1) begin
      failures++;
      $display("FAIL abort_state: dones=%0d sum=%h carry=%0b ready=%0b, required 0 0000 0 1",
               dones, oSum, oCarry, oReady);
    end
    iRstn      = 1'b1;
    last_sum   = '0;
    last_carry = 1'b0;
    step();
    start_op(1'b0, 16'h0003, 16'h0004, 1'b0);
    wait_done(cyc, to, held);
    checks++;
    if (to || cyc != NL + 1 || oSum !== 16'h0007 || oCarry !== 1'b0) begin
      failures++;
      $display("FAIL post_abort_add: cycles=%0d sum=%h carry=%0b, required %0d 0007 0",
               cyc, oSum, oCarry, NL + 1);
    end
    last_sum   = 16'h0007;
    last_carry = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] a [3];
    logic [OW-1:0] b [3];
    bit            s [3];
    bit            c [3];
    int            done_cyc [3];
    int acc = 0, dn = 0, cyc = 0;
    logic [OW:0] exp;
    for (int k = 0; k < 3; k++) begin
      a[k] = OW'($urandom);
      b[k] = OW'($urandom);
      s[k] = 1'($urandom);
      c[k] = 1'($urandom);
    end
    while (dn < 3 && cyc < 40) begin
      if (oReady) begin
        if (acc < 3) begin
          iStart = 1'b1; iA = a[acc]; iB = b[acc]; iSub = s[acc]; iCarry = c[acc];
          acc++;
        end else begin
          iStart = 1'b0;
        end
      end else begin
        iA = OW'($urandom);
        iB = OW'($urandom);
      end
      step();
      cyc++;
      if (oDone) begin
        exp = model(s[dn], a[dn], b[dn], c[dn]);
        done_cyc[dn] = cyc;
        checks++;
        if (oSum !== exp[OW-1:0] || oCarry !== exp[OW]) begin
          failures++;
          $display("FAIL b2b_result[%0d]: sum=%h carry=%0b, required %h %0b",
                   dn, oSum, oCarry, exp[OW-1:0], exp[OW]);
        end
        last_sum   = exp[OW-1:0];
        last_carry = exp[OW];
        dn++;
      end
    end
    iStart = 1'b0;
    checks++;
    if (dn != 3) begin
      failures++;
      $display("FAIL b2b_count: dones=%0d, required 3", dn);
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (done_cyc[k] - done_cyc[k-1] != NL + 2) begin
          failures++;
          $display("FAIL b2b_spacing[%0d]: spacing=%0d, required %0d",
                   k, done_cyc[k] - done_cyc[k-1], NL + 2);
        end
      end
    end
    step();
    step();
  endtask

  task automatic test_random();
    logic [OW-1:0] a, b;
    bit s, c, to, held;
    int cyc;
    logic [OW:0] exp;
    for (int k = 0; k < 25; k++) begin
      a = OW'($urandom);
      b = OW'($urandom);
      if (k % 5 == 0) a = '1;
      if (k % 7 == 0) b = (k % 2 == 0) ? a : '0;
      s = 1'($urandom);
      c = 1'($urandom);
      exp = model(s, a, b, c);
      start_op(s, a, b, c);
      wait_done(cyc, to, held);
      checks++;
      if (to || cyc != NL + 1) begin
        failures++;
        $display("FAIL rand_latency[%0d]: cycles=%0d timeout=%0b, required %0d", k, cyc, to, NL + 1);
      end
      checks++;
      if (oSum !== exp[OW-1:0] || oCarry !== exp[OW]) begin
        failures++;
        $display("FAIL rand_result[%0d]: sub=%0b a=%h b=%h cin=%0b sum=%h carry=%0b, required %h %0b",
                 k, s, a, b, c, oSum, oCarry, exp[OW-1:0], exp[OW]);
      end
      checks++;
      if (!held) begin
        failures++;
        $display("FAIL rand_hold[%0d]: output changed before done, required %h %0b",
                 k, last_sum, last_carry);
      end
      last_sum   = exp[OW-1:0];
      last_carry = exp[OW];
    end
  endtask

  initial begin
    test_reset();
    test_fixed_vectors();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mp_adder_sequencer.md
MP_ADDER_SEQUENCER -- requirements
Module: mp_adder_sequencer

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 32: total operand/result width in bits.
REQ-002 SHALL have parameter ADDER_WIDTH, default 8: limb width processed per cycle.
REQ-003 SHALL have port iClk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port iRstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port iStart  input  1  start request, accepted only when oReady=1.
REQ-006 SHALL have port iSub  input  1  0 = A+B+iCarry, 1 = A-B (two's complement), sampled with iStart.
REQ-007 SHALL have port iA  input  OPERAND_WIDTH  operand A, sampled with iStart.
REQ-008 SHALL have port iB  input  OPERAND_WIDTH  operand B, sampled with iStart.
REQ-009 SHALL have port iCarry  input  1  carry-in for add mode, sampled with iStart; ignored when iSub=1.
REQ-010 SHALL have port oReady  output  1  high only in IDLE.
REQ-011 SHALL have port oDone  output  1  single-cycle pulse, result valid.
REQ-012 SHALL have port oSum  output  OPERAND_WIDTH  result, held until the next completion.
REQ-013 SHALL have port oCarry  output  1  final carry-out (in subtract mode, 1 = no borrow), held with oSum.

Function
REQ-014 SHALL define N_LIMBS = OPERAND_WIDTH/ADDER_WIDTH; OPERAND_WIDTH SHALL be an integer multiple of ADDER_WIDTH, and ADDER_WIDTH SHALL be at least 2.
REQ-015 SHALL implement FSM states IDLE, ADD, DONE: IDLE->ADD on iStart&&oReady, ADD->DONE after limb N_LIMBS-1, DONE->IDLE unconditionally.
REQ-016 On accept, SHALL latch iA, B' = (iSub ? ~iB : iB), and carry register = (iSub ? 1 : iCarry), and clear the limb counter to 0.
REQ-017 In ADD, limb k SHALL be computed each cycle: bits [k*ADDER_WIDTH +: ADDER_WIDTH] of A and B', plus the carry register; the sum limb is written to the result register, the carry register takes the limb carry-out, and the counter increments.
REQ-018 The carry SHALL ripple across limbs through the carry register only; no combinational path SHALL span more than one limb.
REQ-019 oDone SHALL be 1 for exactly the one cycle spent in DONE, i.e. N_LIMBS+1 cycles after the accepting edge; oSum/oCarry SHALL update on entry to DONE and be stable while oDone=1.
REQ-020 oSum and oCarry SHALL NOT change outside of entry to DONE, except on reset.
REQ-021 iStart while not in IDLE SHALL be ignored; no queuing. oReady SHALL be 0 in ADD and DONE.
REQ-022 iStart held high continuously SHALL start a new operation on each return to IDLE (one idle cycle between ops).
REQ-023 Operand inputs SHALL be don't-care except on the accepting cycle.
REQ-024 After the final limb, the counter SHALL wrap to 0; no carry SHALL leak into the next operation.

Reset
REQ-025 While iRstn=0 at a rising edge: state=IDLE, counter=0, carry register=0, oSum=0, oCarry=0, oDone=0, oReady=1 from the following cycle.
REQ-026 Reset asserted mid-operation SHALL abort it with no oDone pulse and leave oSum=0.

Structure
REQ-027 State encoding and the N_LIMBS derivation SHALL live in the shared package arith_pkg.
REQ-028 The per-limb adder SHALL be one instance of ripple_carry_adder_Nb with ADDER_WIDTH=ADDER_WIDTH; the limb mux, B inversion, carry register and FSM are local to this module.

Verification (OPERAND_WIDTH=16, ADDER_WIDTH=4)
REQ-029 Add 0xFFFF+0x0001, iCarry=0 -> oDone exactly 5 cycles after the accepting edge, oSum=0x0000, oCarry=1.
REQ-030 Add 0x1234+0x4321, iCarry=1 -> oSum=0x5556, oCarry=0.
REQ-031 Subtract 0x0001-0x0002 -> oSum=0xFFFF, oCarry=0; subtract 0x1234-0x1234 -> oSum=0x0000, oCarry=1.
REQ-032 iStart pulsed on cycles 2 and 3 after accept with different operands -> ignored, single oDone with the original result, oReady=0 throughout.
REQ-033 iRstn=0 during limb 2 -> no oDone, oSum=0, oReady=1 next cycle; a following add 0x0003+0x0004 -> oSum=0x0007, oCarry=0.
REQ-034 iStart held high for 3 operations -> oDone pulses spaced 6 cycles apart, each with the correct result.
